// File: rtl/add_arbiter.sv
// add_arbiter: shares one 4-bit ripple-carry adder between two requesters.
// A round-robin grant picks one operand pair per transaction. The block then
// returns the registered sum, carry-out and requester id on one response port.
//   clk, rst_n             clock, asynchronous active-low reset
//   req0_valid/ready/a/b   requester 0 operand handshake
//   req1_valid/ready/a/b   requester 1 operand handshake
//   rsp_valid/ready        response handshake
//   rsp_id, rsp_sum, rsp_cout  registered result

// 4-bit ripple-carry adder
module add (
  input  logic [3:0] num1,
  input  logic [3:0] num2,
  output logic [3:0] out,
  output logic       cout
);
  always_comb begin
    logic c;
    c    = 1'b0;
    out  = '0;
    for (int i = 0; i < 4; i++) begin
      out[i] = num1[i] ^ num2[i] ^ c;
      c      = (num1[i] & num2[i]) | (c & (num1[i] ^ num2[i]));
    end
    cout = c;
  end
endmodule

module add_arbiter #(
  parameter logic LAST_INIT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [3:0] rsp_sum,
  output logic       rsp_cout
);
  localparam int unsigned W = 4;

  typedef enum logic {IDLE, RESP} state_t;

  state_t         state, state_d;
  logic           last, last_d;
  logic           rsp_valid_d, rsp_id_d, rsp_cout_d;
  logic [W-1:0]   rsp_sum_d;
  logic           grant;
  logic           accept;
  logic [W-1:0]   add_num1, add_num2, add_out;
  logic           add_cout;

  // Round-robin grant: a tie goes to the requester not served last
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last;
    else if (req1_valid)          grant = 1'b1;
  end

  // Ready is gated by rst_n so both stay low while reset is held
  assign req0_ready = rst_n && (state == IDLE) && req0_valid && !grant;
  assign req1_ready = rst_n && (state == IDLE) && req1_valid &&  grant;
  assign accept     = req0_ready || req1_ready;

  assign add_num1 = grant ? req1_a : req0_a;
  assign add_num2 = grant ? req1_b : req0_b;

  add u_add (
    .num1 (add_num1),
    .num2 (add_num2),
    .out  (add_out),
    .cout (add_cout)
  );

  // Next-state and response register update
  always_comb begin
    state_d     = state;
    last_d      = last;
    rsp_valid_d = rsp_valid;
    rsp_id_d    = rsp_id;
    rsp_sum_d   = rsp_sum;
    rsp_cout_d  = rsp_cout;
    case (state)
      IDLE: begin
        if (accept) begin
          rsp_sum_d   = add_out;
          rsp_cout_d  = add_cout;
          rsp_id_d    = grant;
          last_d      = grant;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= LAST_INIT;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
    end else begin
      state     <= state_d;
      last      <= last_d;
      rsp_valid <= rsp_valid_d;
      rsp_id    <= rsp_id_d;
      rsp_sum   <= rsp_sum_d;
      rsp_cout  <= rsp_cout_d;
    end
  end
endmodule

// File: doc/add_arbiter.md
# add_arbiter

Shares one 4-bit ripple-carry `add` instance between two independent requesters. Each requester presents an operand pair over a valid/ready handshake. A round-robin grant picks one pair per transaction, and the block returns the registered 4-bit sum, carry-out and requester ID on a single valid/ready response port. It sits between the operand sources and the result consumer, and is the only driver of the internal `add` instance's inputs.

## Interface
- `LAST_INIT`, default 1: reset value of the last-served pointer. With 1, requester 0 wins the first tie.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid`  in  1  requester 0 has an operand pair.
- `req0_ready`  out  1  requester 0 pair accepted this cycle.
- `req0_a`, `req0_b`  in  4 each  requester 0 operands.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`: same as requester 0, for requester 1.
- `rsp_valid`  out  1  response registers hold a result.
- `rsp_ready`  in  1  consumer takes the result.
- `rsp_id`  out  1  requester that produced the result.
- `rsp_sum`  out  4  `(a + b) mod 16`.
- `rsp_cout`  out  1  carry-out of bit 3.

## Operation
- Internal `add` instance: `num1` is the granted requester's `a` and `num2` is its `b`, muxed by `grant`. Its outputs are captured, not forwarded combinationally.
- Two-state FSM:
  - IDLE: waiting for a request.
  - RESP: response held.
- Grant rule (combinational, evaluated in IDLE only):
  - only req0_valid: grant = 0.
  - only req1_valid: grant = 1.
  - both valid: grant = ~last.
  - none valid: no grant.
- Ready rule:
  - `reqN_ready` = (state == IDLE) & reqN_valid & (grant == N).
  - Never both high in the same cycle.
  - Always 0 in RESP.
- Accept, on the edge where `reqN_valid & reqN_ready`:
  - `rsp_sum` ← `add.out`, `rsp_cout` ← `add.cout`, `rsp_id` ← N, last ← N.
  - `rsp_valid` ← 1, state ← RESP.
- RESP:
  - `rsp_*` are held stable while `rsp_ready` is 0.
  - On `rsp_valid & rsp_ready`: `rsp_valid` ← 0, state ← IDLE.
  - `rsp_sum`, `rsp_cout` and `rsp_id` keep their last value while `rsp_valid` = 0.
- Requester rule: once valid is asserted, hold valid and operands constant until ready. The block does not check this; violating it is undefined.
- Arithmetic: unsigned 4-bit. The 5-bit result is {cout, sum}, e.g. 9+8 = sum 1, cout 1.
- Non-granted requester: its valid stays pending, unaffected. It wins the next IDLE cycle, because a tie favours the requester not served last.
- Reset (`rst_n` low, any cycle, including mid-RESP):
  - Immediately: state IDLE, `rsp_valid` 0, `rsp_sum` 0, `rsp_cout` 0, `rsp_id` 0, last ← `LAST_INIT`.
  - `req*_ready` are 0 while `rst_n` is low.
  - An in-flight result is discarded.

## Timing
- Ready is a combinational function of valid and state, with zero cycles of request-to-ready latency in IDLE.
- Accept at edge N → `rsp_valid` high in cycle N+1 with final data (latency 1).
- Response handshake at edge M → state is IDLE in cycle M+1; `req*_ready` may go high in that cycle.
- Best-case throughput is one result per 2 cycles. Back-to-back accept in RESP is not supported.
- After `rst_n` deasserts: first accept possible on the first rising edge with a valid request.

## Test plan
- Single request: req0 presents 3+4 and rsp_ready = 1 → req0_ready high that cycle; next cycle rsp_valid = 1, rsp_id = 0, rsp_sum = 7, rsp_cout = 0; IDLE the following cycle.
- Overflow: req1 presents 15+1 → rsp_sum = 0, rsp_cout = 1, rsp_id = 1. Also cover 9+8 → sum 1, cout 1, and 15+15 → sum 14, cout 1.
- Round-robin:
  - Both requesters held valid continuously after reset with LAST_INIT = 1, rsp_ready = 1.
  - Grants alternate 0,1,0,1 over four transactions, each 2 cycles apart.
  - Each requester's data matches its own rsp_id.
- Backpressure:
  - rsp_ready low for 5 cycles after a result: rsp_valid and data are held unchanged, and both req*_ready stay 0.
  - When rsp_ready rises: one handshake, rsp_valid drops next cycle.
- Reset mid-RESP:
  - Assert rst_n low while rsp_valid = 1 → rsp_valid and outputs are 0 without waiting for a clock edge.
  - After release with both valid: requester 0 is granted first (LAST_INIT = 1).
- Exhaustive sweep: all 256 (a, b) pairs through req0, then through req1 → {rsp_cout, rsp_sum} == a + b for every pair.
